// File: rtl/setpoint_ramp_sequencer_if.sv
// Purpose: bundles the start/abort/target request and setpoint/status outputs of the ramp sequencer.
// Latency: none, wires only.
// Backpressure: none; a requester must watch o_busy, since starts outside IDLE are dropped.
interface setpoint_ramp_sequencer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] i_target;
  logic             i_start;
  logic             i_abort;
  logic [WIDTH-1:0] o_setpoint;
  logic [WIDTH-1:0] o_velocity;
  logic             o_dir;
  logic             o_busy;
  logic             o_done;
  logic             o_aborted;
  logic [2:0]       o_state;

  // Requester side: drives the move request, observes the trajectory.
  modport master (
    output i_target, i_start, i_abort,
    input  o_setpoint, o_velocity, o_dir, o_busy, o_done, o_aborted, o_state
  );

  // Sequencer side.
  modport slave (
    input  i_target, i_start, i_abort,
    output o_setpoint, o_velocity, o_dir, o_busy, o_done, o_aborted, o_state
  );
endinterface

// File: rtl/setpoint_ramp_sequencer.sv
// Purpose: trapezoidal position setpoint generator (ACCEL/CRUISE/DECEL, controlled STOP) for the PID sp input.
// Latency: first setpoint update TICK_DIV cycles after the start-accept edge, then one update per tick.
// Backpressure: none; i_start is ignored while busy, i_abort is ignored outside ACCEL/CRUISE/DECEL.
module setpoint_ramp_sequencer #(
  parameter int WIDTH    = 16,
  parameter int TICK_DIV = 50000,
  parameter int ACCEL    = 1,
  parameter int VMAX     = 8
) (
  input logic                      Clk,
  input logic                      i_rst,
  setpoint_ramp_sequencer_if.slave sp_if
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCEL  = 3'd1;
  localparam logic [2:0] ST_CRUISE = 3'd2;
  localparam logic [2:0] ST_DECEL  = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int              CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int              GW        = WIDTH + 1;
  localparam logic [CW-1:0]   TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [GW-1:0]   ACC_G     = GW'(ACCEL);
  localparam logic [GW-1:0]   VMAX_G    = GW'(VMAX);
  localparam logic [WIDTH-1:0] VMAX_W   = WIDTH'(VMAX);

  logic [2:0]       state;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] setpoint;
  logic [WIDTH-1:0] velocity;
  logic [WIDTH-1:0] brk;
  logic             dir;
  logic             done;
  logic             aborted;
  logic [CW-1:0]    cnt;

  logic             tick;
  logic [WIDTH-1:0] rem;
  logic [GW-1:0]    rem_g;
  logic [GW-1:0]    brk_g;
  logic [GW-1:0]    v_g;
  logic             to_decel;
  logic             eff_decel;
  logic [GW-1:0]    v_up;
  logic [GW-1:0]    v_acc;
  logic [GW-1:0]    v_sub;
  logic [GW-1:0]    v_dec;
  logic [GW-1:0]    v_next;
  logic [WIDTH-1:0] v_nw;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] sp_next;
  logic [GW-1:0]    brk_sum;
  logic [WIDTH-1:0] brk_next;

  // Setpoint never passes the target, so the direction picks the non-negative difference.
  assign tick  = (cnt == TICK_LAST);
  assign rem   = dir ? (target - setpoint) : (setpoint - target);
  assign rem_g = {1'b0, rem};
  assign brk_g = {1'b0, brk};
  assign v_g   = {1'b0, velocity};

  // Braking distance already covers what is left: start slowing down this tick.
  assign to_decel  = ((state == ST_ACCEL) || (state == ST_CRUISE)) && (rem_g <= brk_g);
  assign eff_decel = (state == ST_DECEL) || to_decel;

  assign v_up  = v_g + ACC_G;
  assign v_acc = (v_up > VMAX_G) ? VMAX_G : v_up;
  assign v_sub = (v_g > ACC_G) ? (v_g - ACC_G) : '0;
  // DECEL keeps at least one ACCEL of speed so the move always arrives.
  assign v_dec = (v_sub < ACC_G) ? ACC_G : v_sub;

  // Select the post-tick velocity for whichever phase this tick behaves as.
  always_comb begin
    v_next = v_g;
    if (state == ST_STOP) begin
      v_next = v_sub;
    end else if (eff_decel) begin
      v_next = v_dec;
    end else if (state == ST_ACCEL) begin
      v_next = v_acc;
    end
  end

  assign v_nw    = v_next[WIDTH] ? '1 : v_next[WIDTH-1:0];
  // Clamping the step to the remaining distance prevents overshoot and wrap.
  assign step    = (v_nw < rem) ? v_nw : rem;
  assign sp_next = dir ? (setpoint + step) : (setpoint - step);

  // Braking distance grows by the pre-update velocity on every acceleration tick.
  assign brk_sum  = brk_g + v_g;
  assign brk_next = brk_sum[WIDTH] ? '1 : brk_sum[WIDTH-1:0];

  // Tick divider: free-runs while a move (including STOP) is in progress, parked at 0 in IDLE.
  always_ff @(posedge Clk) begin
    if (i_rst) begin
      cnt <= '0;
    end else if ((state == ST_IDLE) || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Trajectory state machine: start latching, per-tick phase updates, abort into STOP.
  always_ff @(posedge Clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      target   <= '0;
      setpoint <= '0;
      velocity <= '0;
      brk      <= '0;
      dir      <= 1'b1;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sp_if.i_start) begin
            target   <= sp_if.i_target;
            dir      <= (sp_if.i_target >= setpoint);
            brk      <= '0;
            velocity <= '0;
            aborted  <= 1'b0;
            if (sp_if.i_target == setpoint) begin
              done <= 1'b1;
            end else begin
              state <= ST_ACCEL;
            end
          end
        end
        ST_ACCEL, ST_CRUISE, ST_DECEL: begin
          // An abort on a tick cycle consumes that tick; STOP takes over from the next one.
          if (sp_if.i_abort) begin
            state <= ST_STOP;
          end else if (tick) begin
            if (rem == '0) begin
              state    <= ST_IDLE;
              velocity <= '0;
              done     <= 1'b1;
            end else begin
              velocity <= v_nw;
              setpoint <= sp_next;
              if ((state == ST_ACCEL) && !to_decel) begin
                brk <= brk_next;
              end
              if (to_decel) begin
                state <= ST_DECEL;
              end else if ((state == ST_ACCEL) && (v_nw == VMAX_W)) begin
                state <= ST_CRUISE;
              end
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            velocity <= v_nw;
            setpoint <= sp_next;
            if (v_nw == '0) begin
              state   <= ST_IDLE;
              done    <= 1'b1;
              aborted <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sp_if.o_setpoint = setpoint;
  assign sp_if.o_velocity = velocity;
  assign sp_if.o_dir      = dir;
  assign sp_if.o_busy     = (state != ST_IDLE);
  assign sp_if.o_done     = done;
  assign sp_if.o_aborted  = aborted;
  assign sp_if.o_state    = state;

endmodule
